// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: flag bit positions, write-port roles,
// the register select type and the masked flag merge.
package exec_pkg;

    localparam int EXEC_SEL_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int WR_ALU  = 0;
    localparam int WR_LOAD = 1;

    typedef logic [EXEC_SEL_W-1:0] reg_sel_t;

    // Bits selected by we take the new value; the rest keep the old value.
    function automatic logic [3:0] flag_merge(input logic [3:0] old_flags,
                                              input logic [3:0] new_flags,
                                              input logic [3:0] we);
        return (old_flags & ~we) | (new_flags & we);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight producer and
// raises stall when a read operand is busy and not being written back now.
module reg_scoreboard
    import exec_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2,
    parameter int SEL_W    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    not_enable,
    input  logic                    iss_en,
    input  logic [SEL_W-1:0]        iss_sel,
    input  logic [1:0]              wr_en,
    input  logic [2*SEL_W-1:0]      wr_sel,
    input  logic [NUM_RD*SEL_W-1:0] rd_sel,
    output logic                    stall
);

    logic [NUM_REGS-1:0] busy;
    logic [SEL_W-1:0]    wsel [2];

    always_comb begin
        wsel[WR_ALU]  = wr_sel[WR_ALU*SEL_W +: SEL_W];
        wsel[WR_LOAD] = wr_sel[WR_LOAD*SEL_W +: SEL_W];
    end

    // A new issue outranks a write-back to the same register: it names a newer producer.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else if (!not_enable) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (iss_en && iss_sel == SEL_W'(r)) begin
                    busy[r] <= 1'b1;
                end else if ((wr_en[WR_ALU]  && wsel[WR_ALU]  == SEL_W'(r)) ||
                             (wr_en[WR_LOAD] && wsel[WR_LOAD] == SEL_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [SEL_W-1:0] s;
        logic             hit;
        stall = 1'b0;
        s     = '0;
        hit   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            s   = rd_sel[p*SEL_W +: SEL_W];
            hit = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (s == SEL_W'(r)) hit = busy[r];
            end
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k] && wsel[k] == s) hit = 1'b0;
            end
            stall = stall | hit;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports with write bypass,
// ALU and load write-back ports (load wins), masked flags and a scoreboard.
module reg_file_mp
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2,
    parameter int SEL_W    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     not_enable,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [1:0]               wr_en,
    input  logic [2*SEL_W-1:0]       wr_sel,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic [3:0]               flags_we,
    input  logic [3:0]               in_flags,
    output logic [3:0]               out_flags,
    input  logic                     iss_en,
    input  logic [SEL_W-1:0]         iss_sel,
    output logic                     stall
);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [SEL_W-1:0]         wsel [2];
    logic [DATA_W-1:0]        wdat [2];
    logic [1:0]               wr_commit;
    logic [NUM_RD*DATA_W-1:0] rd_next;

    // A write commits only when enabled, unfrozen and aimed at a mapped register.
    always_comb begin
        wr_commit = '0;
        for (int k = 0; k < 2; k++) begin
            wsel[k] = wr_sel[k*SEL_W +: SEL_W];
            wdat[k] = wr_data[k*DATA_W +: DATA_W];
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wsel[k] == SEL_W'(r)) wr_commit[k] = wr_en[k] && !not_enable;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_commit[WR_LOAD] && wsel[WR_LOAD] == SEL_W'(r)) begin
                    regs[r] <= wdat[WR_LOAD];
                end else if (wr_commit[WR_ALU] && wsel[WR_ALU] == SEL_W'(r)) begin
                    regs[r] <= wdat[WR_ALU];
                end
            end
        end
    end

    // Read mux: stored value, overridden by ALU then load bypass; unmapped reads 0.
    always_comb begin
        logic [SEL_W-1:0] s;
        rd_next = '0;
        s       = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            s = rd_sel[p*SEL_W +: SEL_W];
            for (int r = 0; r < NUM_REGS; r++) begin
                if (s == SEL_W'(r)) rd_next[p*DATA_W +: DATA_W] = regs[r];
            end
            if (wr_commit[WR_ALU] && wsel[WR_ALU] == s) begin
                rd_next[p*DATA_W +: DATA_W] = wdat[WR_ALU];
            end
            if (wr_commit[WR_LOAD] && wsel[WR_LOAD] == s) begin
                rd_next[p*DATA_W +: DATA_W] = wdat[WR_LOAD];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data   <= '0;
            out_flags <= '0;
        end else begin
            rd_data <= rd_next;
            if (!not_enable) out_flags <= flag_merge(out_flags, in_flags, flags_we);
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .SEL_W    (SEL_W)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .not_enable (not_enable),
        .iss_en     (iss_en),
        .iss_sel    (iss_sel),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .rd_sel     (rd_sel),
        .stall      (stall)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, dual-write priority, bypass, flag
// masking, scoreboard stall, freeze and unmapped indices.
module tb_reg_file_mp;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NR = 2;

    logic            clock;
    logic            reset;
    logic            not_enable;
    logic [NR*SW-1:0] rd_sel;
    logic [NR*DW-1:0] rd_data;
    logic [1:0]      wr_en;
    logic [2*SW-1:0] wr_sel;
    logic [2*DW-1:0] wr_data;
    logic [3:0]      flags_we;
    logic [3:0]      in_flags;
    logic [3:0]      out_flags;
    logic            iss_en;
    logic [SW-1:0]   iss_sel;
    logic            stall;

    int checks = 0;
    int errors = 0;

    reg_file_mp #(
        .DATA_W   (DW),
        .NUM_REGS (15),
        .NUM_RD   (NR),
        .SEL_W    (SW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .not_enable (not_enable),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .flags_we   (flags_we),
        .in_flags   (in_flags),
        .out_flags  (out_flags),
        .iss_en     (iss_en),
        .iss_sel    (iss_sel),
        .stall      (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int k, input logic [SW-1:0] sel, input logic [DW-1:0] data);
        wr_en[k] = 1'b1;
        wr_sel[k*SW +: SW] = sel;
        wr_data[k*DW +: DW] = data;
    endtask

    task automatic rd(input int p, input logic [SW-1:0] sel);
        rd_sel[p*SW +: SW] = sel;
    endtask

    initial begin
        reset = 1'b1; not_enable = 1'b0; rd_sel = '0; wr_en = '0; wr_sel = '0;
        wr_data = '0; flags_we = '0; in_flags = '0; iss_en = 1'b0; iss_sel = '0;
        step(); step();
        reset = 1'b0;
        check("reset_rd0", rd_data[DW-1:0], 32'h0);
        check("reset_rd1", rd_data[2*DW-1:DW], 32'h0);
        check("reset_flags", 32'(out_flags), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);

        // r3 written, read back, then cleared by reset
        wr(WR_ALU, 4'd3, 32'hDEADBEEF); step();
        wr_en = '0; rd(0, 4'd3); step();
        check("r3_written", rd_data[DW-1:0], 32'hDEADBEEF);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_rd_data", rd_data[DW-1:0], 32'h0);
        step();
        check("r3_after_reset", rd_data[DW-1:0], 32'h0);
        check("flags_after_reset", 32'(out_flags), 32'h0);
        check("stall_after_reset", 32'(stall), 32'h0);

        // both ports to r5: load wins, in the bypass and in storage
        wr(WR_ALU, 4'd5, 32'h11); wr(WR_LOAD, 4'd5, 32'h22); rd(0, 4'd5); rd(1, 4'd4); step();
        check("dual_bypass", rd_data[DW-1:0], 32'h22);
        wr_en = '0; rd(1, 4'd5); step();
        check("dual_stored", rd_data[2*DW-1:DW], 32'h22);

        // bypass of a new value over an old stored value on both read ports
        wr(WR_ALU, 4'd7, 32'h1234); rd(0, 4'd0); rd(1, 4'd0); step();
        wr(WR_ALU, 4'd7, 32'hA5A5A5A5); rd(0, 4'd7); rd(1, 4'd7); step();
        check("bypass_rd0", rd_data[DW-1:0], 32'hA5A5A5A5);
        check("bypass_rd1", rd_data[2*DW-1:DW], 32'hA5A5A5A5);
        wr_en = '0; step();
        check("bypass_stored", rd_data[DW-1:0], 32'hA5A5A5A5);

        // flag mask: Z and V set, N and C hold
        in_flags = 4'b1111; flags_we = 4'b0101; step();
        check("flag_mask", 32'(out_flags), 32'((1 << FLAG_Z) | (1 << FLAG_V)));
        flags_we = 4'b0000; in_flags = 4'b0000; step();
        check("flag_hold", 32'(out_flags), 32'h5);
        flags_we = 4'b0100; step();
        check("flag_clear_z", 32'(out_flags), 32'h1);
        flags_we = 4'b0000;

        // scoreboard: issue r2, read stalls, load write-back hides it, then clears it
        rd(0, 4'd0); rd(1, 4'd0);
        iss_en = 1'b1; iss_sel = 4'd2; step();
        iss_en = 1'b0; rd(0, 4'd2); #1;
        check("stall_busy", 32'(stall), 32'h1);
        rd(0, 4'd0); rd(1, 4'd2); #1;
        check("stall_busy_port1", 32'(stall), 32'h1);
        rd(1, 4'd0); rd(0, 4'd2);
        wr(WR_LOAD, 4'd2, 32'h77); #1;
        check("stall_writeback", 32'(stall), 32'h0);
        step();
        check("wb_bypass", rd_data[DW-1:0], 32'h77);
        wr_en = '0; #1;
        check("stall_cleared", 32'(stall), 32'h0);

        // issue and write-back of r2 in one cycle: set wins
        rd(0, 4'd0);
        iss_en = 1'b1; iss_sel = 4'd2; wr(WR_ALU, 4'd2, 32'h88); step();
        iss_en = 1'b0; wr_en = '0; rd(0, 4'd2); #1;
        check("set_wins", 32'(stall), 32'h1);
        wr(WR_ALU, 4'd2, 32'h99); step();
        wr_en = '0; #1;
        check("set_then_clear", 32'(stall), 32'h0);

        // freeze: write, issue and flag update on r1 all ignored
        rd(0, 4'd1);
        not_enable = 1'b1; wr(WR_ALU, 4'd1, 32'h5); iss_en = 1'b1; iss_sel = 4'd1;
        flags_we = 4'b1111; in_flags = 4'b1010; step();
        check("freeze_no_bypass", rd_data[DW-1:0], 32'h0);
        check("freeze_flags", 32'(out_flags), 32'h1);
        rd(0, 4'd7); step();
        check("freeze_read_tracks", rd_data[DW-1:0], 32'hA5A5A5A5);
        not_enable = 1'b0; wr_en = '0; iss_en = 1'b0; flags_we = '0; rd(0, 4'd1); #1;
        check("freeze_not_busy", 32'(stall), 32'h0);
        step();
        check("freeze_r1", rd_data[DW-1:0], 32'h0);

        // unmapped index 15: writes, bypass and issue all ignored
        wr(WR_LOAD, 4'd15, 32'hFFFF_FFFF); rd(0, 4'd15); step();
        check("unmapped_bypass", rd_data[DW-1:0], 32'h0);
        wr_en = '0; iss_en = 1'b1; iss_sel = 4'd15; step();
        check("unmapped_read", rd_data[DW-1:0], 32'h0);
        iss_en = 1'b0; #1;
        check("unmapped_not_busy", 32'(stall), 32'h0);

        // reset overrides a same-cycle write and issue
        wr(WR_ALU, 4'd9, 32'h1357); iss_en = 1'b1; iss_sel = 4'd9; rd(0, 4'd9);
        reset = 1'b1; step();
        reset = 1'b0; wr_en = '0; iss_en = 1'b0; #1;
        check("reset_over_issue", 32'(stall), 32'h0);
        step();
        check("reset_over_write", rd_data[DW-1:0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
